// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// R-type function codes and the ALUop codes understood by alu32.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_mc_control_alu_decoder.sv
// R-type function decoder: maps Funct to the alu32 operation and flags
// whether the function is one this core implements.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic       legal
);

    // Funct lookup; unknown codes fall back to ADD and are marked illegal
    always_comb begin
        aluop = ALU_ADD;
        legal = 1'b1;
        case (funct)
            FN_ADD:  aluop = ALU_ADD;
            FN_SUB:  aluop = ALU_SUB;
            FN_AND:  aluop = ALU_AND;
            FN_OR:   aluop = ALU_OR;
            FN_SLT:  aluop = ALU_SLT;
            FN_NOR:  aluop = ALU_NOR;
            default: begin
                aluop = ALU_ADD;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences each instruction through its states
// and decodes the datapath controls directly from the current state.
module mips_mc_control
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUop,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] fn_aluop_s;
    logic       fn_legal_s;
    logic       op_known_s;

    alu_decoder u_alu_decoder (
        .funct (Funct),
        .aluop (fn_aluop_s),
        .legal (fn_legal_s)
    );

    // Opcodes that DECODE can dispatch; R-type additionally needs a legal Funct
    always_comb begin
        op_known_s = 1'b0;
        case (Op)
            OP_RTYPE: op_known_s = fn_legal_s;
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_known_s = 1'b1;
            default:  op_known_s = 1'b0;
        endcase
    end

    // Next-state sequencing
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = fn_legal_s ? S_EXEC : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode; reset forces every control low so an aborted
    // instruction can never write the register file or memory
    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        ALUop    = ALU_ADD;
        Illegal  = 1'b0;
        State    = state_q;
        if (reset) begin
            ALUop = 4'b0000;
            State = 4'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCEn    = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    Illegal = ~op_known_s;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUop   = fn_aluop_s;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUop    = ALU_SUB;
                    PCSource = 2'b01;
                    PCEn     = Zero;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCEn     = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                default: begin
                    ALUop = 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class through the
// FSM and compares State and the packed control word every cycle.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUop, State;
    logic       Illegal;

    int total = 0;
    int bad   = 0;

    // {PCEn,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALUop,Illegal}
    logic [17:0] ctl;
    assign ctl = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSource, ALUop, Illegal};

    localparam logic [17:0] E_ZERO   = 18'b0_0_0_0_0_0_0_0_0_00_00_0000_0;
    localparam logic [17:0] E_FETCH  = 18'b1_0_1_0_1_0_0_0_0_01_00_0010_0;
    localparam logic [17:0] E_DECODE = 18'b0_0_0_0_0_0_0_0_0_11_00_0010_0;
    localparam logic [17:0] E_DECILL = 18'b0_0_0_0_0_0_0_0_0_11_00_0010_1;
    localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_0_0_0_1_10_00_0010_0;
    localparam logic [17:0] E_MEMRD  = 18'b0_1_1_0_0_0_0_0_0_00_00_0010_0;
    localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_0_1_1_0_00_00_0010_0;
    localparam logic [17:0] E_MEMWR  = 18'b0_1_0_1_0_0_0_0_0_00_00_0010_0;
    localparam logic [17:0] E_EXNOR  = 18'b0_0_0_0_0_0_0_0_1_00_00_1100_0;
    localparam logic [17:0] E_ALUWB  = 18'b0_0_0_0_0_1_0_1_0_00_00_0010_0;
    localparam logic [17:0] E_BRZ1   = 18'b1_0_0_0_0_0_0_0_1_00_01_0110_0;
    localparam logic [17:0] E_BRZ0   = 18'b0_0_0_0_0_0_0_0_1_00_01_0110_0;
    localparam logic [17:0] E_JUMP   = 18'b1_0_0_0_0_0_0_0_0_00_10_0010_0;
    localparam logic [17:0] E_ADDIWB = 18'b0_0_0_0_0_0_0_1_0_00_00_0010_0;

    mips_mc_control dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSource (PCSource),
        .ALUop    (ALUop),
        .Illegal  (Illegal),
        .State    (State)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Op    = 6'b100011;
        Funct = 6'b000000;
        Zero  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (ctl !== E_ZERO) begin
                bad++;
                $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, ctl, E_ZERO);
            end
            total++;
            if (State !== 4'd0) begin
                bad++;
                $display("FAIL reset_state[%0d] got=%0d exp=0", i, State);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0) begin
            bad++;
            $display("FAIL post_reset_state got=%0d exp=0", State);
        end
        total++;
        if (ctl !== E_FETCH) begin
            bad++;
            $display("FAIL post_reset_ctl got=%b exp=%b", ctl, E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [17:0] ec [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        Op = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL lw_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_rtype_nor();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic [17:0] ec [5] = '{E_FETCH, E_DECODE, E_EXNOR, E_ALUWB, E_FETCH};
        Op    = 6'b000000;
        Funct = 6'b100111;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL nor_state[%0d] got=%0d exp=%0d", i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL nor_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        logic [17:0] ec [4] = '{E_FETCH, E_DECODE, (z ? E_BRZ1 : E_BRZ0), E_FETCH};
        Op = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            Zero = (i == 2) ? z : ~z;
            #1;
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL beq_z%0d_state[%0d] got=%0d exp=%0d", z, i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL beq_z%0d_ctl[%0d] got=%b exp=%b", z, i, ctl, ec[i]);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_jump_addi();
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        logic [17:0] ec [8] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH, E_DECODE, E_MEMADR,
                                E_ADDIWB, E_FETCH};
        for (int i = 0; i < 8; i++) begin
            Op = (i < 3) ? 6'b000010 : 6'b001000;
            #1;
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL j_addi_state[%0d] got=%0d exp=%0d", i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL j_addi_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        logic [17:0] ec [5] = '{E_FETCH, E_DECILL, E_FETCH, E_DECILL, E_FETCH};
        for (int i = 0; i < 5; i++) begin
            Op    = (i < 2) ? 6'b111111 : 6'b000000;
            Funct = 6'b000000;
            #1;
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL illegal_state[%0d] got=%0d exp=%0d", i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL illegal_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]);
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [17:0] ec [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        Op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (State !== es[i]) begin
                bad++;
                $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, State, es[i]);
            end
            total++;
            if (ctl !== ec[i]) begin
                bad++;
                $display("FAIL sw_ctl[%0d] got=%b exp=%b", i, ctl, ec[i]);
            end
            if (i < 3) step();
        end
        reset = 1'b1;
        #1;
        total++;
        if (MemWrite !== 1'b0 || ctl !== E_ZERO) begin
            bad++;
            $display("FAIL sw_reset_ctl got=%b exp=%b", ctl, E_ZERO);
        end
        step();
        total++;
        if (ctl !== E_ZERO) begin
            bad++;
            $display("FAIL sw_reset_hold_ctl got=%b exp=%b", ctl, E_ZERO);
        end
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0) begin
            bad++;
            $display("FAIL sw_release_state got=%0d exp=0", State);
        end
        total++;
        if (ctl !== E_FETCH) begin
            bad++;
            $display("FAIL sw_release_ctl got=%b exp=%b", ctl, E_FETCH);
        end
        step();
        total++;
        if (State !== 4'd1) begin
            bad++;
            $display("FAIL sw_restart_state got=%0d exp=1", State);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_nor();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump_addi();
        test_illegal();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
